// File: rtl/thunderbird_pkg.sv
// Shared types and constants for the Thunderbird tail-light monitor.
package thunderbird_pkg;

  typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3, ERR} mon_state_t;

  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_1   = 3'b100;
  localparam logic [2:0] PAT_2   = 3'b110;
  localparam logic [2:0] PAT_3   = 3'b111;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  function automatic logic [1:0] dir_of(input mon_state_t s);
    case (s)
      L1, L2, L3: dir_of = DIR_LEFT;
      R1, R2, R3: dir_of = DIR_RIGHT;
      default:    dir_of = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/thunderbird_lamp_monitor_sat_counter.sv
// Event counter that either wraps (SAT=0) or holds at all-ones (SAT=1).
module sat_counter #(
  parameter int W   = 8,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc) begin
      if (SAT != 0 && (&count)) begin
        count <= count;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/thunderbird_lamp_monitor.sv
// Observes the six tail-light lines, tracks the running turn sequence and
// reports completed sequences and illegal lamp patterns.
module thunderbird_lamp_monitor
  import thunderbird_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             la,
  input  logic             lb,
  input  logic             lc,
  input  logic             ra,
  input  logic             rb,
  input  logic             rc,
  output logic [1:0]       dir,
  output logic             done_l,
  output logic             done_r,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic             err,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
);

  mon_state_t state, nxt;
  logic [2:0] lpat, rpat;
  logic       both_off, inc_l, inc_r, inc_e;

  assign lpat     = {la, lb, lc};
  assign rpat     = {ra, rb, rc};
  assign both_off = (lpat == PAT_OFF) && (rpat == PAT_OFF);

  // Anything that is not the single expected next step lands in ERR.
  always_comb begin
    nxt = ERR;
    case (state)
      IDLE: begin
        if (both_off)                                nxt = IDLE;
        else if (lpat == PAT_1 && rpat == PAT_OFF)   nxt = L1;
        else if (rpat == PAT_1 && lpat == PAT_OFF)   nxt = R1;
      end
      L1: if (lpat == PAT_2 && rpat == PAT_OFF) nxt = L2;
      L2: if (lpat == PAT_3 && rpat == PAT_OFF) nxt = L3;
      L3: if (both_off)                         nxt = IDLE;
      R1: if (rpat == PAT_2 && lpat == PAT_OFF) nxt = R2;
      R2: if (rpat == PAT_3 && lpat == PAT_OFF) nxt = R3;
      R3: if (both_off)                         nxt = IDLE;
      ERR: nxt = both_off ? IDLE : ERR;
      default: nxt = ERR;
    endcase
  end

  assign inc_l = sample_en && (state == L3) && (nxt == IDLE);
  assign inc_r = sample_en && (state == R3) && (nxt == IDLE);
  assign inc_e = sample_en && (state != ERR) && (nxt == ERR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      dir        <= DIR_NONE;
      done_l     <= 1'b0;
      done_r     <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      done_l <= inc_l;
      done_r <= inc_r;
      err    <= inc_e;
      if (sample_en) begin
        state <= nxt;
        dir   <= dir_of(nxt);
      end
      if (inc_e) err_sticky <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W), .SAT(0)) u_left_cnt (
    .clk(clk), .reset(reset), .inc(inc_l), .count(left_cnt)
  );

  sat_counter #(.W(CNT_W), .SAT(0)) u_right_cnt (
    .clk(clk), .reset(reset), .inc(inc_r), .count(right_cnt)
  );

  sat_counter #(.W(ERR_W), .SAT(1)) u_err_cnt (
    .clk(clk), .reset(reset), .inc(inc_e), .count(err_cnt)
  );

endmodule

// File: tb/tb_thunderbird_lamp_monitor.sv
// Directed and randomized checking of thunderbird_lamp_monitor against a
// sequence-step reference model, using narrow counters to reach wrap/saturation.
module tb_thunderbird_lamp_monitor;

  localparam int CNT_W = 2;
  localparam int ERR_W = 2;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset, sample_en;
  logic             la, lb, lc, ra, rb, rc;
  logic [1:0]       dir;
  logic             done_l, done_r, err, err_sticky;
  logic [CNT_W-1:0] left_cnt, right_cnt;
  logic [ERR_W-1:0] err_cnt;

  thunderbird_lamp_monitor #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en),
    .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
    .dir(dir), .done_l(done_l), .done_r(done_r),
    .left_cnt(left_cnt), .right_cnt(right_cnt),
    .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  string phase = "init";

  // Reference model: which side is running (0 none, 1 left, 2 right, 3 error)
  // and how many steps of the lamp sequence have been seen on that side.
  logic [2:0] seq [4] = '{3'b100, 3'b110, 3'b111, 3'b000};
  int m_side = 0, m_step = 0;
  int e_dir = 0, e_dl = 0, e_dr = 0, e_err = 0, e_sticky = 0;
  int e_lc = 0, e_rc = 0, e_ec = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL [%s] %s: got %0d expected %0d at %0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit en, input logic [2:0] l, input logic [2:0] r, input bit rst_n);
    bit both_off, bad, fin;
    logic [2:0] own, other;
    e_dl = 0; e_dr = 0; e_err = 0;
    if (!rst_n) begin
      m_side = 0; m_step = 0; e_dir = 0; e_sticky = 0;
      e_lc = 0; e_rc = 0; e_ec = 0;
      return;
    end
    if (!en) return;
    both_off = (l == 3'b000) && (r == 3'b000);
    bad = 0; fin = 0;
    if (m_side == 3) begin
      if (both_off) m_side = 0;
    end else if (m_side == 0) begin
      if (both_off) ;
      else if (l == 3'b100 && r == 3'b000) begin m_side = 1; m_step = 1; end
      else if (r == 3'b100 && l == 3'b000) begin m_side = 2; m_step = 1; end
      else bad = 1;
    end else begin
      own   = (m_side == 1) ? l : r;
      other = (m_side == 1) ? r : l;
      if (own == seq[m_step] && other == 3'b000) begin
        if (m_step == 3) fin = 1;
        else m_step++;
      end else bad = 1;
    end
    if (fin) begin
      if (m_side == 1) begin e_dl = 1; e_lc = (e_lc + 1) % CNT_MOD; end
      else begin e_dr = 1; e_rc = (e_rc + 1) % CNT_MOD; end
      m_side = 0;
    end
    if (bad) begin
      m_side = 3; e_err = 1; e_sticky = 1;
      if (e_ec < ERR_MAX) e_ec++;
    end
    e_dir = (m_side == 1) ? 1 : (m_side == 2) ? 2 : 0;
  endtask

  task automatic step(input bit en, input logic [2:0] l, input logic [2:0] r, input bit rst_n = 1'b1);
    sample_en = en; {la, lb, lc} = l; {ra, rb, rc} = r; reset = rst_n;
    @(posedge clk);
    model(en, l, r, rst_n);
    #1;
    chk("dir", 32'(dir), 32'(e_dir));
    chk("done_l", 32'(done_l), 32'(e_dl));
    chk("done_r", 32'(done_r), 32'(e_dr));
    chk("err", 32'(err), 32'(e_err));
    chk("err_sticky", 32'(err_sticky), 32'(e_sticky));
    chk("left_cnt", 32'(left_cnt), 32'(e_lc));
    chk("right_cnt", 32'(right_cnt), 32'(e_rc));
    chk("err_cnt", 32'(err_cnt), 32'(e_ec));
    chk("pulse_excl", 32'(int'(done_l) + int'(done_r) + int'(err) <= 1), 32'd1);
  endtask

  task automatic left_seq();
    step(1, 3'b100, 3'b000); step(1, 3'b110, 3'b000);
    step(1, 3'b111, 3'b000); step(1, 3'b000, 3'b000);
  endtask

  task automatic right_seq();
    step(1, 3'b000, 3'b100); step(1, 3'b000, 3'b110);
    step(1, 3'b000, 3'b111); step(1, 3'b000, 3'b000);
  endtask

  initial begin
    logic [2:0] l, r;
    bit en, rn;

    phase = "reset";
    repeat (3) step(1, 3'b111, 3'b101, 1'b0);
    step(1, 3'b000, 3'b000);

    phase = "left_seq";
    left_seq();

    phase = "skip_step";
    step(1, 3'b000, 3'b100); step(1, 3'b000, 3'b111); step(1, 3'b000, 3'b000);
    right_seq();

    phase = "both_lit";
    step(1, 3'b000, 3'b000, 1'b0);
    repeat (4) step(1, 3'b100, 3'b100);
    step(1, 3'b000, 3'b000);

    phase = "enable_gate";
    step(1, 3'b000, 3'b000, 1'b0);
    step(1, 3'b100, 3'b000); step(1, 3'b110, 3'b000);
    step(0, 3'b011, 3'b101); step(0, 3'b000, 3'b000);
    step(1, 3'b111, 3'b000); step(1, 3'b000, 3'b000);

    phase = "wrap_sat";
    step(1, 3'b000, 3'b000, 1'b0);
    repeat (5) left_seq();
    repeat (5) begin step(1, 3'b010, 3'b000); step(1, 3'b000, 3'b000); end

    phase = "reset_mid";
    step(1, 3'b100, 3'b000); step(1, 3'b110, 3'b000);
    step(1, 3'b111, 3'b000, 1'b0);
    step(1, 3'b110, 3'b000);
    step(1, 3'b000, 3'b000);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 99) < 85);
      rn = ($urandom_range(0, 299) != 0);
      l = 3'b000; r = 3'b000;
      if (m_side == 0) begin
        case ($urandom_range(0, 2))
          1: l = 3'b100;
          2: r = 3'b100;
          default: ;
        endcase
      end else if (m_side == 1) l = seq[m_step];
      else if (m_side == 2) r = seq[m_step];
      if ($urandom_range(0, 99) < 12) begin
        l = 3'($urandom_range(0, 7));
        r = 3'($urandom_range(0, 7));
      end
      step(en, l, r, rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/thunderbird_lamp_monitor.md
Name: thunderbird_lamp_monitor

Overview:
- Observer at the output end of the Thunderbird tail-light controller. Samples the six lamp lines each enabled cycle.
- Decodes which turn sequence is running and checks the lamp sequence cycle by cycle. Counts completed sequences and flags illegal patterns.
- Used in hardware self-check and as the bench-side scoreboard for the light FSM.

Parameters:
- CNT_W, 8, width of the left/right completed-sequence counters; these wrap modulo 2^CNT_W.
- ERR_W, 4, width of the error counter; it saturates at 2^ERR_W-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- sample_en  in  1  when 1, the lamp inputs are evaluated this cycle; when 0, all state holds and pulses are 0.
- la, lb, lc  in  1 each  left lamps, inner to outer.
- ra, rb, rc  in  1 each  right lamps, inner to outer.
- dir  out  2  decoded direction: 00 none, 01 left, 10 right.
- done_l  out  1  one-cycle pulse when a left sequence completes.
- done_r  out  1  one-cycle pulse when a right sequence completes.
- left_cnt  out  CNT_W  number of completed left sequences.
- right_cnt  out  CNT_W  number of completed right sequences.
- err  out  1  one-cycle pulse on an illegal pattern.
- err_sticky  out  1  set by any error; cleared only by reset.
- err_cnt  out  ERR_W  saturating error count.

Behaviour:
- Reset: reset=0 at a rising edge forces state=IDLE and all outputs to 0. This applies mid-sequence too; there is no partial count.
- Pattern notation: L = {la,lb,lc}, R = {ra,rb,rc}. Legal lit patterns per side are P1=100, P2=110, P3=111; OFF=000.
- State set: IDLE, L1, L2, L3, R1, R2, R3, ERR.
- Transitions are evaluated only when sample_en=1:
  - IDLE: L=OFF and R=OFF -> IDLE. L=P1 and R=OFF -> L1. R=P1 and L=OFF -> R1. Anything else -> ERR.
  - L1: L=P2, R=OFF -> L2. L2: L=P3, R=OFF -> L3. L3: L=OFF, R=OFF -> IDLE, done_l=1, left_cnt+1.
  - R1/R2/R3 mirror L1/L2/L3 on R, with done_r and right_cnt.
  - Any other pattern in L1..R3 -> ERR. This includes a repeated pattern, a skipped step, both sides lit, and an opposite-side lamp lit.
  - ERR: L=OFF and R=OFF -> IDLE, with no error. Anything else -> stay in ERR, with no new error.
- Error event: a transition into ERR from any state other than ERR gives err=1 for one cycle, err_sticky=1, and err_cnt+1 (saturating at max).
- Latency: all outputs are registered. A pattern sampled at edge k is reflected after edge k, i.e. visible during cycle k+1.
- dir is registered from the next state: 01 in L1..L3, 10 in R1..R3, 00 in IDLE and ERR.
- Counters: left_cnt and right_cnt wrap from 2^CNT_W-1 to 0. err_cnt holds at all-ones.
- Pulses done_l, done_r and err are mutually exclusive by construction; at most one is high per cycle.
- When sample_en=0: state, counters and dir hold; done_l, done_r and err are 0.

Decomposition:
- thunderbird_pkg holds:
  - typedef enum logic [2:0] mon_state_t {IDLE, L1, L2, L3, R1, R2, R3, ERR}
  - localparams PAT_OFF=3'b000, PAT_1=3'b100, PAT_2=3'b110, PAT_3=3'b111
  - localparams DIR_NONE=2'b00, DIR_LEFT=2'b01, DIR_RIGHT=2'b10
- One sub-module, sat_counter (parameters W and SAT), instantiated for err_cnt (SAT=1) and for both sequence counters (SAT=0, wrap).

Test Plan:
- Reset hold, then a full left sequence: L=100, 110, 111, 000 with R=000 on consecutive cycles with sample_en=1 -> dir=01,01,01,00; done_l=1 exactly once, one cycle after the 000 sample; left_cnt=1; err never set.
- Skip step: IDLE, R=100, then R=111 -> err=1 one cycle after the 111 sample; err_sticky=1; err_cnt=1; dir=00. Then R=000 -> IDLE, and a following clean right sequence gives right_cnt=1.
- Both sides lit: L=100 and R=100 from IDLE -> err=1, err_cnt=1. Holding the pattern 3 more cycles -> err_cnt stays 1.
- Enable gating: left sequence with sample_en=0 inserted for 2 cycles between P2 and P3 -> state holds, no err, completes with done_l=1 and left_cnt=1.
- Wrap and saturate with CNT_W=2, ERR_W=2: 5 left sequences -> left_cnt=1. 5 separate error events -> err_cnt=3.
- Reset mid-sequence: reset=0 while in L2 -> next cycle dir=00, all counters 0, err_sticky=0; sampling L=110 next -> err=1.
